// File: rtl/dffram_arb_pkg.sv
// Shared types and helpers for the DFFRAM arbiter: owner encoding,
// Wishbone port states and byte-lane extraction from a core bit mask.
package dffram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CORE = 2'd2,
        OWN_WB   = 2'd3
    } owner_e;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_e;

    localparam int LANES = 4;

    // A byte lane is written when any bit of that byte is set in the mask.
    function automatic logic [LANES-1:0] mask_to_lanes(input logic [31:0] mask);
        logic [LANES-1:0] lanes;
        lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            lanes[i] = |mask[8*i +: 8];
        end
        return lanes;
    endfunction

endpackage

// File: rtl/dffram_arb_wb_port.sv
// Wishbone side of the DFFRAM arbiter: request generation, starvation
// counter, the IDLE/ACK handshake FSM and read-data return.
// Build option: DFFRAM_ARB_WB_EN. When defined, Wishbone competes for the
// RAM and the starvation counter is present. When undefined, Wishbone never
// touches the RAM, but every strobe is still acknowledged one cycle later
// with zero read data.
module dffram_arb_wb_port
    import dffram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        gnt,
    input  logic        rd_pending,
    input  logic [31:0] ram_do,
    output logic        req,
    output logic        force_win,
    output logic        ack,
    output logic [31:0] dat
);

    wb_state_e state;
    wb_state_e state_next;
    logic      start;

`ifdef DFFRAM_ARB_WB_EN

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    assign req       = cyc & stb & (state == WB_IDLE);
    assign force_win = (starve_cnt == LIMIT);
    assign start     = gnt;

    // Count consecutive denied cycles of a pending request; saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!req || gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign dat = (ack && rd_pending) ? ram_do : 32'h0;

`else

    logic unused_inputs;

    assign req           = 1'b0;
    assign force_win     = 1'b0;
    assign start         = cyc & stb;
    assign dat           = 32'h0;
    assign unused_inputs = ^{gnt, rd_pending, ram_do};

`endif

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An accepted strobe moves to ACK; ACK always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            WB_IDLE: begin
                if (start) begin
                    state_next = WB_ACK;
                end
            end
            WB_ACK: begin
                state_next = WB_IDLE;
            end
            default: begin
                state_next = WB_IDLE;
            end
        endcase
    end

    assign ack = (state == WB_ACK) & ~rst;

endmodule

// File: rtl/dffram_arbiter.sv
// Single-port arbiter sharing one 32-bit DFFRAM macro between the UART
// program loader, the core memory port and the Caravel Wishbone slave.
// Priority: loader > starved Wishbone > core > Wishbone. The read owner is
// registered so that the next-cycle RAM output is routed to the right port.
// Build option: DFFRAM_ARB_WB_EN enables Wishbone access to the RAM.
module dffram_arbiter
    import dffram_arb_pkg::*;
#(
    parameter int AW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [31:0]   ld_wdata_i,

    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [31:0]   core_wdata_i,
    input  logic [31:0]   core_wmask_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [31:0]   core_rdata_o,

    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,

    output logic          ram_en_o,
    output logic [3:0]    ram_we_o,
    output logic [AW-1:0] ram_a_o,
    output logic [31:0]   ram_di_o,
    input  logic [31:0]   ram_do_i
);

    owner_e        owner;
    owner_e        rd_owner_q;
    logic          wb_req;
    logic          wb_force;
    logic          wb_gnt;
    logic [AW-1:0] wb_word;
    logic          unused_adr_bits;

    assign wb_word         = wbs_adr_i[AW+1:2];
    assign unused_adr_bits = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

    dffram_arb_wb_port #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_wb_port (
        .clk        (clk_i),
        .rst        (rst_i),
        .cyc        (wbs_cyc_i),
        .stb        (wbs_stb_i),
        .gnt        (wb_gnt),
        .rd_pending (rd_owner_q == OWN_WB),
        .ram_do     (ram_do_i),
        .req        (wb_req),
        .force_win  (wb_force),
        .ack        (wbs_ack_o),
        .dat        (wbs_dat_o)
    );

    // Pick one owner per cycle; the loader keeps working while the SoC is in reset.
    always_comb begin
        owner = OWN_NONE;
        if (ld_we_i) begin
            owner = OWN_LD;
        end else if (!rst_i) begin
            if (wb_req && wb_force) begin
                owner = OWN_WB;
            end else if (core_req_i) begin
                owner = OWN_CORE;
            end else if (wb_req) begin
                owner = OWN_WB;
            end
        end
    end

    // Drive the RAM and the grants from the chosen owner; idle RAM inputs are zero.
    always_comb begin
        ram_en_o   = 1'b0;
        ram_we_o   = 4'h0;
        ram_a_o    = '0;
        ram_di_o   = 32'h0;
        core_gnt_o = 1'b0;
        wb_gnt     = 1'b0;
        case (owner)
            OWN_LD: begin
                ram_en_o = 1'b1;
                ram_we_o = 4'hF;
                ram_a_o  = ld_addr_i;
                ram_di_o = ld_wdata_i;
            end
            OWN_CORE: begin
                core_gnt_o = 1'b1;
                ram_en_o   = 1'b1;
                ram_we_o   = core_we_i ? mask_to_lanes(core_wmask_i) : 4'h0;
                ram_a_o    = core_addr_i;
                ram_di_o   = core_wdata_i;
            end
            OWN_WB: begin
                wb_gnt   = 1'b1;
                ram_en_o = 1'b1;
                ram_we_o = wbs_we_i ? wbs_sel_i : 4'h0;
                ram_a_o  = wb_word;
                ram_di_o = wbs_dat_i;
            end
            default: begin
                ram_en_o = 1'b0;
            end
        endcase
    end

    // Remember who issued a read so next cycle's RAM output goes back to them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_owner_q <= OWN_NONE;
        end else if (owner == OWN_CORE && !core_we_i) begin
            rd_owner_q <= OWN_CORE;
        end else if (owner == OWN_WB && !wbs_we_i) begin
            rd_owner_q <= OWN_WB;
        end else begin
            rd_owner_q <= OWN_NONE;
        end
    end

    assign core_rvalid_o = (rd_owner_q == OWN_CORE) & ~rst_i;
    assign core_rdata_o  = core_rvalid_o ? ram_do_i : 32'h0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a behavioural DFFRAM model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// DFFRAM_ARB_WB_EN selects which Wishbone scenario is exercised.
module tb_dffram_arbiter;

    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [31:0]   core_wdata;
    logic [31:0]   core_wmask;
    logic          core_gnt;
    logic          core_rvalid;
    logic [31:0]   core_rdata;
    logic          wbs_cyc;
    logic          wbs_stb;
    logic          wbs_we;
    logic [3:0]    wbs_sel;
    logic [31:0]   wbs_adr;
    logic [31:0]   wbs_dat_w;
    logic          wbs_ack;
    logic [31:0]   wbs_dat_r;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_di;
    logic [31:0]   ram_do;

    logic [31:0]   mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    dffram_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ld_we_i       (ld_we),
        .ld_addr_i     (ld_addr),
        .ld_wdata_i    (ld_wdata),
        .core_req_i    (core_req),
        .core_we_i     (core_we),
        .core_addr_i   (core_addr),
        .core_wdata_i  (core_wdata),
        .core_wmask_i  (core_wmask),
        .core_gnt_o    (core_gnt),
        .core_rvalid_o (core_rvalid),
        .core_rdata_o  (core_rdata),
        .wbs_cyc_i     (wbs_cyc),
        .wbs_stb_i     (wbs_stb),
        .wbs_we_i      (wbs_we),
        .wbs_sel_i     (wbs_sel),
        .wbs_adr_i     (wbs_adr),
        .wbs_dat_i     (wbs_dat_w),
        .wbs_ack_o     (wbs_ack),
        .wbs_dat_o     (wbs_dat_r),
        .ram_en_o      (ram_en),
        .ram_we_o      (ram_we),
        .ram_a_o       (ram_a),
        .ram_di_o      (ram_di),
        .ram_do_i      (ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DFFRAM model: byte-lane writes, registered read data on enabled cycles.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) begin
                    mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
                end
            end
            ram_do <= mem[ram_a];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [AW-1:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] wmask);
        core_req   = req;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wdata;
        core_wmask = wmask;
    endtask

    task automatic driveLoader(input logic we, input logic [AW-1:0] addr, input logic [31:0] data);
        ld_we    = we;
        ld_addr  = addr;
        ld_wdata = data;
    endtask

    task automatic driveWb(input logic cs, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] data);
        wbs_cyc   = cs;
        wbs_stb   = cs;
        wbs_we    = we;
        wbs_sel   = sel;
        wbs_adr   = adr;
        wbs_dat_w = data;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ram_do = 32'h0;
        driveLoader(1'b0, '0, 32'h0);
        applyStimulus(1'b0, 1'b0, '0, 32'h0, 32'h0);
        driveWb(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        nextCycle();
        #1;
        checkOutput("rst_rvalid", {31'h0, core_rvalid}, 32'h0);
        checkOutput("rst_ack", {31'h0, wbs_ack}, 32'h0);
        checkOutput("rst_wbdat", wbs_dat_r, 32'h0);
        checkOutput("rst_rdata", core_rdata, 32'h0);

        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h03, 32'h0, 32'h0);
        driveLoader(1'b1, 8'h10, 32'hCAFEF00D);
        #1;
        checkOutput("rst_ld_gnt", {31'h0, core_gnt}, 32'h0);
        checkOutput("rst_ld_en", {31'h0, ram_en}, 32'h1);
        checkOutput("rst_ld_we", {28'h0, ram_we}, 32'hF);
        checkOutput("rst_ld_a", {24'h0, ram_a}, 32'h10);

        nextCycle();
        driveLoader(1'b1, 8'h03, 32'h12345678);
        #1;
        checkOutput("rst_ld2_gnt", {31'h0, core_gnt}, 32'h0);
        nextCycle();
        driveLoader(1'b1, 8'h00, 32'h5A5A5A5A);
        #1;
        checkOutput("rst_ld3_gnt", {31'h0, core_gnt}, 32'h0);
        nextCycle();
        driveLoader(1'b1, 8'h20, 32'h0);
        #1;
        checkOutput("rst_ld4_gnt", {31'h0, core_gnt}, 32'h0);
        nextCycle();
        driveLoader(1'b0, '0, 32'h0);
        #1;
        checkOutput("rst_req_gnt", {31'h0, core_gnt}, 32'h0);
        checkOutput("rst_req_en", {31'h0, ram_en}, 32'h0);

        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 32'h0);
        #1;
        checkOutput("rd0_gnt", {31'h0, core_gnt}, 32'h1);
        checkOutput("rd0_a", {24'h0, ram_a}, 32'h10);
        checkOutput("rd0_rvalid", {31'h0, core_rvalid}, 32'h0);

        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h03, 32'h0, 32'h0);
        #1;
        checkOutput("rd1_gnt", {31'h0, core_gnt}, 32'h1);
        checkOutput("rd0_rvalid1", {31'h0, core_rvalid}, 32'h1);
        checkOutput("rd0_rdata", core_rdata, 32'hCAFEF00D);

        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 32'h0, 32'h0);
        #1;
        checkOutput("rd1_rvalid", {31'h0, core_rvalid}, 32'h1);
        checkOutput("rd1_rdata", core_rdata, 32'h12345678);

        nextCycle();
        applyStimulus(1'b1, 1'b1, 8'h20, 32'hAABBCCDD, 32'h0000FF00);
        #1;
        checkOutput("wr_gnt", {31'h0, core_gnt}, 32'h1);
        checkOutput("wr_we", {28'h0, ram_we}, 32'h2);
        checkOutput("idle_rvalid", {31'h0, core_rvalid}, 32'h0);

        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 32'h0);
        #1;
        checkOutput("wr_no_rvalid", {31'h0, core_rvalid}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 32'h0, 32'h0);
        #1;
        checkOutput("mask_rdata", core_rdata, 32'h0000CC00);

        nextCycle();
        driveLoader(1'b1, 8'h30, 32'h11111111);
        applyStimulus(1'b1, 1'b1, 8'h31, 32'h22222222, 32'hFFFFFFFF);
        #1;
        checkOutput("coll_gnt0", {31'h0, core_gnt}, 32'h0);
        checkOutput("coll_a0", {24'h0, ram_a}, 32'h30);
        nextCycle();
        driveLoader(1'b0, '0, 32'h0);
        #1;
        checkOutput("coll_gnt1", {31'h0, core_gnt}, 32'h1);
        checkOutput("coll_a1", {24'h0, ram_a}, 32'h31);
        checkOutput("coll_we1", {28'h0, ram_we}, 32'hF);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h30, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h31, 32'h0, 32'h0);
        #1;
        checkOutput("coll_ld_data", core_rdata, 32'h11111111);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 32'h0, 32'h0);
        #1;
        checkOutput("coll_core_data", core_rdata, 32'h22222222);
        checkOutput("none_en", {31'h0, ram_en}, 32'h0);
        checkOutput("none_a", {24'h0, ram_a}, 32'h0);
        checkOutput("none_di", ram_di, 32'h0);

        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 32'h0);
        #1;
        checkOutput("drop_gnt", {31'h0, core_gnt}, 32'h1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 32'h0, 32'h0);
        #1;
        checkOutput("drop_rvalid", {31'h0, core_rvalid}, 32'h0);
        checkOutput("drop_rdata", core_rdata, 32'h0);
        nextCycle();
        rst = 1'b0;

`ifdef DFFRAM_ARB_WB_EN
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 32'h0);
        driveWb(1'b1, 1'b0, 4'hF, 32'h0000000C, 32'h0);
        #1;
        checkOutput("starve_gnt0", {31'h0, core_gnt}, 32'h1);
        for (int c = 1; c < 4; c++) begin
            nextCycle();
            #1;
            checkOutput("starve_gnt", {31'h0, core_gnt}, 32'h1);
            checkOutput("starve_ack", {31'h0, wbs_ack}, 32'h0);
        end
        nextCycle();
        #1;
        checkOutput("force_gnt", {31'h0, core_gnt}, 32'h0);
        checkOutput("force_a", {24'h0, ram_a}, 32'h03);
        checkOutput("force_we", {28'h0, ram_we}, 32'h0);
        nextCycle();
        driveWb(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("force_ack", {31'h0, wbs_ack}, 32'h1);
        checkOutput("force_dat", wbs_dat_r, 32'h12345678);
        checkOutput("resume_gnt", {31'h0, core_gnt}, 32'h1);
        checkOutput("resume_rvalid0", {31'h0, core_rvalid}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 32'h0, 32'h0);
        #1;
        checkOutput("ack_once", {31'h0, wbs_ack}, 32'h0);
        checkOutput("resume_rdata", core_rdata, 32'hCAFEF00D);

        nextCycle();
        driveWb(1'b1, 1'b1, 4'b0001, 32'h00000080, 32'h11223344);
        #1;
        checkOutput("wbwr_we", {28'h0, ram_we}, 32'h1);
        checkOutput("wbwr_a", {24'h0, ram_a}, 32'h20);
        nextCycle();
        driveWb(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("wbwr_ack", {31'h0, wbs_ack}, 32'h1);
        checkOutput("wbwr_dat", wbs_dat_r, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 32'h0, 32'h0);
        #1;
        checkOutput("wbwr_rdata", core_rdata, 32'h0000CC44);
`else
        nextCycle();
        driveWb(1'b1, 1'b1, 4'hF, 32'h00000000, 32'hFFFFFFFF);
        #1;
        checkOutput("nowb_en", {31'h0, ram_en}, 32'h0);
        checkOutput("nowb_ack0", {31'h0, wbs_ack}, 32'h0);
        nextCycle();
        driveWb(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("nowb_ack1", {31'h0, wbs_ack}, 32'h1);
        checkOutput("nowb_dat", wbs_dat_r, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 32'h0);
        #1;
        checkOutput("nowb_ack2", {31'h0, wbs_ack}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, 32'h0, 32'h0);
        #1;
        checkOutput("nowb_rdata", core_rdata, 32'h5A5A5A5A);
`endif

        nextCycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
